fpaddsub_round_stage: RTL

Parametrised, pipelined successor to the FP add/sub rounding stage. It takes the normalised sign, exponent, mantissa and R/S bits from the normalisation stage and applies one of four IEEE-754 rounding modes. It also saturates the result correctly on overflow and produces the packed result and exception flags. It is the final stage of the pipelined FPAddSub datapath, with a two-deep registered pipeline and valid/ready handshakes on both sides.

---
 rtl/fpaddsub_round_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fpaddsub_round_stage.sv
// Final FP add/sub stage: rounds the normalised result, saturates on overflow, packs Z and Flags.
// Latency 2 cycles (S1 operand/round-decision register, S2 result register), 1 result/cycle.
// Backpressure: valid/ready on both sides, bubbles collapse, in_ready combinational from out_ready.
// Optional feature macro FPADDSUB_ROUND_MODES_EN: when defined, RMode selects RNE/RTZ/RUP/RDN and
// mode-dependent overflow saturation; when undefined, rounding is fixed to RNE and overflow gives
// signed infinity (RMode port is kept but ignored).
module fpaddsub_round_stage #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   ZeroSum,
   input  logic                   Sgn,
   input  logic                   NegE,
   input  logic [EXP_W:0]         NormE,
   input  logic [MAN_W-1:0]       NormM,
   input  logic                   R,
   input  logic                   S,
   input  logic                   Sa,
   input  logic                   Sb,
   input  logic                   Ctrl,
   input  logic                   MaxAB,
   input  logic [4:0]             InputExc,
   input  logic [1:0]             RMode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   Z,
   output logic [4:0]             Flags
);

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   // Sgn and InputExc[2:1] are not needed here: the sign is re-derived from the operand signs.
   logic unused_ok;
`ifdef FPADDSUB_ROUND_MODES_EN
   assign unused_ok = ^{Sgn, InputExc[2:1]};
`else
   assign unused_ok = ^{Sgn, InputExc[2:1], RMode};
`endif

   // ---------------- handshake ----------------
   logic s1_valid_q, s2_valid_q;
   logic s1_adv, s2_adv;

   assign s2_adv    = ~s2_valid_q | out_ready;
   assign s1_adv    = ~s1_valid_q | s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;

   // ---------------- stage 1 inputs ----------------
   logic             fsgn_d;
   logic             rup_d;
   logic [MAN_W:0]   minc_d;

   assign fsgn_d = (ZeroSum & (Sa ^ Sb)) |
                   (ZeroSum ? (Sa & Sb & ~Ctrl)
                            : ((~MaxAB & Sa) | ((Ctrl ^ Sb) & (MaxAB | Sa))));

   // Mantissa increment is done early so S2 only has to select and carry into the exponent.
   assign minc_d = {1'b0, NormM} + {{MAN_W{1'b0}}, 1'b1};

   // Round-up decision from the guard/sticky bits and the selected rounding mode.
   always_comb begin
      rup_d = R & (S | NormM[0]);
`ifdef FPADDSUB_ROUND_MODES_EN
      case (RMode)
         RM_RNE:  rup_d = R & (S | NormM[0]);
         RM_RTZ:  rup_d = 1'b0;
         RM_RUP:  rup_d = ~fsgn_d & (R | S);
         RM_RDN:  rup_d = fsgn_d & (R | S);
         default: rup_d = R & (S | NormM[0]);
      endcase
`endif
   end

   // ---------------- stage 1 registers ----------------
   logic             s1_fsgn_q, s1_rup_q;
   logic [MAN_W:0]   s1_minc_q;
   logic [MAN_W-1:0] s1_m_q;
   logic [EXP_W:0]   s1_e_q;
   logic             s1_nege_q, s1_zs_q, s1_spec_q, s1_inv_q, s1_rs_q;
`ifdef FPADDSUB_ROUND_MODES_EN
   logic [1:0]       s1_rmode_q;
`endif

   // S1 captures a new operand set whenever it is empty or its contents move on to S2.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_fsgn_q  <= fsgn_d;
            s1_rup_q   <= rup_d;
            s1_minc_q  <= minc_d;
            s1_m_q     <= NormM;
            s1_e_q     <= NormE;
            s1_nege_q  <= NegE;
            s1_zs_q    <= ZeroSum;
            s1_spec_q  <= InputExc[0];
            s1_inv_q   <= InputExc[3] | InputExc[4];
            s1_rs_q    <= R | S;
`ifdef FPADDSUB_ROUND_MODES_EN
            s1_rmode_q <= RMode;
`endif
         end
      end
   end

   // ---------------- stage 2 combinational ----------------
   logic [MAN_W-1:0]     round_m;
   logic [EXP_W:0]       round_e;
   logic                 ovf;
   logic                 sat_inf;
   logic [EXP_W+MAN_W:0] z_d;
   logic [4:0]           flags_d;

   assign round_m = s1_rup_q ? s1_minc_q[MAN_W-1:0] : s1_m_q;
   // The exponent is held at all-ones rather than wrapping back to zero.
   assign round_e = (&s1_e_q) ? s1_e_q
                              : s1_e_q + {{EXP_W{1'b0}}, s1_rup_q & s1_minc_q[MAN_W]};

   assign ovf = (round_e[EXP_W] | (&round_e[EXP_W-1:0])) & ~s1_nege_q & ~s1_zs_q & ~s1_spec_q;

   // Overflow goes to infinity unless the mode rounds toward zero for this sign.
   always_comb begin
      sat_inf = 1'b1;
`ifdef FPADDSUB_ROUND_MODES_EN
      case (s1_rmode_q)
         RM_RNE:  sat_inf = 1'b1;
         RM_RTZ:  sat_inf = 1'b0;
         RM_RUP:  sat_inf = ~s1_fsgn_q;
         RM_RDN:  sat_inf = s1_fsgn_q;
         default: sat_inf = 1'b1;
      endcase
`endif
   end

   // Packed result: saturated value on overflow, otherwise the rounded fields.
   always_comb begin
      z_d = {s1_fsgn_q, round_e[EXP_W-1:0], round_m};
      if (ovf) begin
         if (sat_inf)
            z_d = {s1_fsgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         else
            z_d = {s1_fsgn_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end
   end

   assign flags_d = {ovf, s1_nege_q, 1'b0, s1_inv_q, s1_rs_q | (ovf & ~s1_spec_q)};

   // ---------------- stage 2 registers ----------------
   logic [EXP_W+MAN_W:0] z_q;
   logic [4:0]           flags_q;

   // S2 holds the result stable until downstream takes it; reset clears the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         z_q        <= '0;
         flags_q    <= '0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            z_q     <= z_d;
            flags_q <= flags_d;
         end
      end
   end

   assign Z     = z_q;
   assign Flags = flags_q;

endmodule
